// File: rtl/capture_reg_bank_pkg.sv
// Shared types and helpers for the capture register bank: idle FSM state
// encoding and the counter-width helper used to size idle_cnt.
package capture_reg_bank_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    COUNT  = 2'd1,
    IDLE   = 2'd2
  } idle_state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/capture_channel.sv
// One flop-based capture channel: optional synchronous reset to a fixed value,
// optional capture-once lock, and a sticky valid flag.
module capture_channel #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               HAS_RST = 1'b1,
  parameter bit               ONCE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             rearm,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             locked,
  output logic             eff
);

  // Power-up value applies to every channel, including ones that ignore reset.
  logic [WIDTH-1:0] q_r = RST_VAL;
  logic             valid_r;

  assign q     = q_r;
  assign valid = valid_r;

  always_ff @(posedge clk) begin
    if (reset && HAS_RST) begin
      q_r <= RST_VAL;
    end else if (eff) begin
      q_r <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else if (eff) begin
      valid_r <= 1'b1;
    end
  end

  generate
    if (ONCE) begin : g_once
      logic lock_r;

      // A same-cycle rearm unlocks in time for the capture, which then relocks.
      assign eff    = en & ~(lock_r & ~rearm);
      assign locked = lock_r;

      always_ff @(posedge clk) begin
        if (reset) begin
          lock_r <= 1'b0;
        end else if (eff) begin
          lock_r <= 1'b1;
        end else if (rearm) begin
          lock_r <= 1'b0;
        end
      end
    end else begin : g_free
      logic unused_rearm;
      assign unused_rearm = rearm;
      assign eff          = en;
      assign locked       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/capture_reg_bank.sv
// Bank of per-channel capture registers with a saturating capture-event
// counter and an idle detector driven by the raw enables.
module capture_reg_bank
  import capture_reg_bank_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      WIDTH       = 1,
  parameter logic [NUM_CH*WIDTH-1:0] RST_VAL     = (NUM_CH*WIDTH)'(3'b010),
  parameter logic [NUM_CH-1:0]       RST_MASK    = NUM_CH'(3'b011),
  parameter logic [NUM_CH-1:0]       ONCE_MASK   = NUM_CH'(3'b000),
  parameter int                      IDLE_CYCLES = 16,
  parameter int                      CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] d_in,
  input  logic [NUM_CH-1:0]       d_en,
  input  logic [NUM_CH-1:0]       rearm,
  input  logic                    clr_count,
  output logic [NUM_CH*WIDTH-1:0] d_out,
  output logic [NUM_CH-1:0]       d_valid,
  output logic [NUM_CH-1:0]       locked,
  output logic                    idle,
  output logic [CNT_W-1:0]        en_count
);

  localparam int             IW        = cnt_width(IDLE_CYCLES);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] eff;
  logic              any_eff;
  logic              any_en;

  idle_state_t       state;
  logic [IW-1:0]     idle_cnt;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      capture_channel #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL[i*WIDTH +: WIDTH]),
        .HAS_RST(RST_MASK[i]),
        .ONCE   (ONCE_MASK[i])
      ) u_ch (
        .clk   (clk),
        .reset (reset),
        .d     (d_in[i*WIDTH +: WIDTH]),
        .en    (d_en[i]),
        .rearm (rearm[i]),
        .q     (d_out[i*WIDTH +: WIDTH]),
        .valid (d_valid[i]),
        .locked(locked[i]),
        .eff   (eff[i])
      );
    end
  endgenerate

  assign any_eff = |eff;
  assign any_en  = |d_en;

  // Clear takes effect first so a same-cycle capture still counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_count <= '0;
    end else if (clr_count) begin
      en_count <= any_eff ? CNT_W'(1) : '0;
    end else if (any_eff && (en_count != CNT_MAX)) begin
      en_count <= en_count + 1'b1;
    end
  end

  // idle_cnt holds the number of enable-free cycles already seen in COUNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COUNT;
      idle_cnt <= '0;
      idle     <= 1'b0;
    end else begin
      case (state)
        ACTIVE: begin
          idle <= 1'b0;
          if (!any_en) begin
            state    <= COUNT;
            idle_cnt <= IW'(1);
          end
        end
        COUNT: begin
          if (any_en) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
            idle     <= 1'b0;
          end else if (idle_cnt == IDLE_LAST) begin
            state <= IDLE;
            idle  <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            idle     <= 1'b0;
          end
        end
        IDLE: begin
          if (any_en) begin
            state <= ACTIVE;
            idle  <= 1'b0;
          end else begin
            idle <= 1'b1;
          end
        end
        default: begin
          state    <= COUNT;
          idle_cnt <= '0;
          idle     <= 1'b0;
        end
      endcase
    end
  end

endmodule
